// File: rtl/model_controller_gradient_accumulator.sv
// Streams x(t) and d(t) vectors and accumulates dW = sum d*(t) x(t)^T and db = sum d*(t) over T steps.
// Define MODEL_GRADIENT_SATURATE_EN for saturating products/sums; default build wraps modulo 2^DATA_SIZE.
module model_controller_gradient_accumulator #(
    parameter int DATA_SIZE = 64,
    parameter int MAX_L     = 4,
    parameter int MAX_X     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 BUSY,
    output logic                 ERROR,
    input  logic                 MODE_IN,
    input  logic [DATA_SIZE-1:0] SIZE_L_IN,
    input  logic [DATA_SIZE-1:0] SIZE_X_IN,
    input  logic [DATA_SIZE-1:0] SIZE_T_IN,
    input  logic                 X_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] X_IN,
    output logic                 X_IN_READY,
    input  logic                 D_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] D_IN,
    output logic                 D_IN_READY,
    output logic                 W_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] W_OUT,
    output logic                 B_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] B_OUT
);
    localparam int LW = (MAX_L > 1) ? $clog2(MAX_L) : 1;
    localparam int XW = (MAX_X > 1) ? $clog2(MAX_X) : 1;
    localparam logic signed [DATA_SIZE-1:0] S_ONE  = DATA_SIZE'(1);
    localparam logic signed [DATA_SIZE-1:0] S_MAXL = DATA_SIZE'(MAX_L);
    localparam logic signed [DATA_SIZE-1:0] S_MAXX = DATA_SIZE'(MAX_X);

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_D, ACCUM, OUT_W, OUT_B} state_t;
    state_t state;

    logic signed [DATA_SIZE-1:0] x_store [MAX_X];
    logic signed [DATA_SIZE-1:0] d_store [MAX_L];
    logic signed [DATA_SIZE-1:0] prev_d  [MAX_L];
    logic signed [DATA_SIZE-1:0] acc_w   [MAX_L][MAX_X];
    logic signed [DATA_SIZE-1:0] acc_b   [MAX_L];

    logic [LW-1:0]        li, l_last;
    logic [XW-1:0]        xi, x_last;
    logic [DATA_SIZE-1:0] t_cnt, t_last;
    logic                 mode;
    logic                 size_ok;

    logic signed [DATA_SIZE-1:0] d_cur, d_star, prod, w_sum, b_sum;

    assign size_ok = ($signed(SIZE_L_IN) >= S_ONE) && ($signed(SIZE_L_IN) <= S_MAXL) &&
                     ($signed(SIZE_X_IN) >= S_ONE) && ($signed(SIZE_X_IN) <= S_MAXX) &&
                     ($signed(SIZE_T_IN) >= S_ONE);

    assign d_cur  = d_store[li];
    assign d_star = mode ? d_cur - prev_d[li] : d_cur;

`ifdef MODEL_GRADIENT_SATURATE_EN
    localparam logic signed [DATA_SIZE-1:0] SMAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] SMIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    function automatic logic signed [DATA_SIZE-1:0] sat_add(input logic signed [DATA_SIZE-1:0] a,
                                                            input logic signed [DATA_SIZE-1:0] b);
        logic [DATA_SIZE:0] s;
        s = {a[DATA_SIZE-1], a} + {b[DATA_SIZE-1], b};
        if (s[DATA_SIZE] != s[DATA_SIZE-1])
            return s[DATA_SIZE] ? SMIN : SMAX;
        return s[DATA_SIZE-1:0];
    endfunction

    logic signed [2*DATA_SIZE-1:0] prod_full;
    assign prod_full = (2*DATA_SIZE)'(d_star) * (2*DATA_SIZE)'(x_store[xi]);
    // The product fits when every bit above the sign position agrees with it.
    assign prod  = (&prod_full[2*DATA_SIZE-1:DATA_SIZE-1] || ~|prod_full[2*DATA_SIZE-1:DATA_SIZE-1])
                   ? prod_full[DATA_SIZE-1:0] : (prod_full[2*DATA_SIZE-1] ? SMIN : SMAX);
    assign w_sum = sat_add(acc_w[li][xi], prod);
    assign b_sum = sat_add(acc_b[li], d_star);
`else
    assign prod  = d_star * x_store[xi];
    assign w_sum = acc_w[li][xi] + prod;
    assign b_sum = acc_b[li] + d_star;
`endif

    assign BUSY       = (state != IDLE);
    assign X_IN_READY = (state == LOAD_X);
    assign D_IN_READY = (state == LOAD_D);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            mode         <= 1'b0;
            li           <= '0;
            xi           <= '0;
            l_last       <= '0;
            x_last       <= '0;
            t_cnt        <= '0;
            t_last       <= '0;
            READY        <= 1'b0;
            ERROR        <= 1'b0;
            W_OUT_ENABLE <= 1'b0;
            B_OUT_ENABLE <= 1'b0;
            W_OUT        <= '0;
            B_OUT        <= '0;
            for (int i = 0; i < MAX_X; i++) x_store[i] <= '0;
            for (int l = 0; l < MAX_L; l++) begin
                d_store[l] <= '0;
                prev_d[l]  <= '0;
                acc_b[l]   <= '0;
                for (int x = 0; x < MAX_X; x++) acc_w[l][x] <= '0;
            end
        end else begin
            READY <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    if (size_ok) begin
                        state  <= LOAD_X;
                        ERROR  <= 1'b0;
                        mode   <= MODE_IN;
                        l_last <= LW'(SIZE_L_IN - DATA_SIZE'(1));
                        x_last <= XW'(SIZE_X_IN - DATA_SIZE'(1));
                        t_last <= SIZE_T_IN - DATA_SIZE'(1);
                        t_cnt  <= '0;
                        li     <= '0;
                        xi     <= '0;
                        for (int l = 0; l < MAX_L; l++) begin
                            prev_d[l] <= '0;
                            acc_b[l]  <= '0;
                            for (int x = 0; x < MAX_X; x++) acc_w[l][x] <= '0;
                        end
                    end else begin
                        ERROR <= 1'b1;
                        READY <= 1'b1;
                    end
                end
                LOAD_X: if (X_IN_ENABLE) begin
                    x_store[xi] <= X_IN;
                    if (xi == x_last) begin
                        xi    <= '0;
                        state <= LOAD_D;
                    end else begin
                        xi <= xi + XW'(1);
                    end
                end
                LOAD_D: if (D_IN_ENABLE) begin
                    d_store[li] <= D_IN;
                    if (li == l_last) begin
                        li    <= '0;
                        state <= ACCUM;
                    end else begin
                        li <= li + LW'(1);
                    end
                end
                ACCUM: begin
                    acc_w[li][xi] <= w_sum;
                    if (xi == '0) acc_b[li] <= b_sum;
                    if (xi == x_last) begin
                        xi <= '0;
                        if (li == l_last) begin
                            li <= '0;
                            for (int l = 0; l < MAX_L; l++) prev_d[l] <= d_store[l];
                            if (t_cnt == t_last) begin
                                state        <= OUT_W;
                                W_OUT_ENABLE <= 1'b1;
                                // A 1x1 result is being written this very edge, so forward it.
                                W_OUT <= (l_last == '0 && x_last == '0) ? w_sum : acc_w[0][0];
                            end else begin
                                t_cnt <= t_cnt + DATA_SIZE'(1);
                                state <= LOAD_X;
                            end
                        end else begin
                            li <= li + LW'(1);
                        end
                    end else begin
                        xi <= xi + XW'(1);
                    end
                end
                OUT_W: begin
                    if (xi == x_last && li == l_last) begin
                        xi           <= '0;
                        li           <= '0;
                        state        <= OUT_B;
                        W_OUT_ENABLE <= 1'b0;
                        B_OUT_ENABLE <= 1'b1;
                        B_OUT        <= acc_b[0];
                    end else if (xi == x_last) begin
                        xi    <= '0;
                        li    <= li + LW'(1);
                        W_OUT <= acc_w[li + LW'(1)][0];
                    end else begin
                        xi    <= xi + XW'(1);
                        W_OUT <= acc_w[li][xi + XW'(1)];
                    end
                end
                OUT_B: begin
                    if (li == l_last) begin
                        li           <= '0;
                        state        <= IDLE;
                        B_OUT_ENABLE <= 1'b0;
                        READY        <= 1'b1;
                    end else begin
                        li    <= li + LW'(1);
                        B_OUT <= acc_b[li + LW'(1)];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_model_controller_gradient_accumulator.sv
// Scoreboard bench: directed runs push expected W/B/READY values, a negedge monitor pops and compares.
module tb_model_controller_gradient_accumulator;
    localparam int N = 64;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic         start, start8, mode, xen, den;
    logic [N-1:0] sl, sx, st, xin, din;
    logic         ready, busy, err, x_rdy, d_rdy, w_en, b_en;
    logic [N-1:0] w_out, b_out;
    logic         ready8, busy8, err8, x_rdy8, d_rdy8, w_en8, b_en8;
    logic [7:0]   w_out8, b_out8;

    model_controller_gradient_accumulator u_dut (
        .CLK(CLK), .RST(RST), .START(start), .READY(ready), .BUSY(busy), .ERROR(err),
        .MODE_IN(mode), .SIZE_L_IN(sl), .SIZE_X_IN(sx), .SIZE_T_IN(st),
        .X_IN_ENABLE(xen), .X_IN(xin), .X_IN_READY(x_rdy),
        .D_IN_ENABLE(den), .D_IN(din), .D_IN_READY(d_rdy),
        .W_OUT_ENABLE(w_en), .W_OUT(w_out), .B_OUT_ENABLE(b_en), .B_OUT(b_out)
    );

    model_controller_gradient_accumulator #(.DATA_SIZE(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .START(start8), .READY(ready8), .BUSY(busy8), .ERROR(err8),
        .MODE_IN(mode), .SIZE_L_IN(sl[7:0]), .SIZE_X_IN(sx[7:0]), .SIZE_T_IN(st[7:0]),
        .X_IN_ENABLE(xen), .X_IN(xin[7:0]), .X_IN_READY(x_rdy8),
        .D_IN_ENABLE(den), .D_IN(din[7:0]), .D_IN_READY(d_rdy8),
        .W_OUT_ENABLE(w_en8), .W_OUT(w_out8), .B_OUT_ENABLE(b_en8), .B_OUT(b_out8)
    );

    int checks = 0;
    int failures = 0;
    logic [N-1:0] exp_w[$], exp_b[$];
    logic [7:0]   exp_w8[$], exp_b8[$];
    bit           exp_r[$], exp_r8[$];
    bit           sel;
    logic [N-1:0] xs[16], ds[16];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic extra(input string name);
        checks++;
        failures++;
        $display("FAIL %s: output presented with nothing expected", name);
    endtask

    // Monitor: every output strobe must match the head of its expectation queue.
    always @(negedge CLK) begin
        if (w_en)   begin if (exp_w.size()  != 0) chk("w_out",  w_out, exp_w.pop_front()); else extra("w_out"); end
        if (b_en)   begin if (exp_b.size()  != 0) chk("b_out",  b_out, exp_b.pop_front()); else extra("b_out"); end
        if (ready)  begin if (exp_r.size()  != 0) chk("ready_error", 64'(err), 64'(exp_r.pop_front())); else extra("ready"); end
        if (w_en8)  begin if (exp_w8.size() != 0) chk("w_out8", 64'(w_out8), 64'(exp_w8.pop_front())); else extra("w_out8"); end
        if (b_en8)  begin if (exp_b8.size() != 0) chk("b_out8", 64'(b_out8), 64'(exp_b8.pop_front())); else extra("b_out8"); end
        if (ready8) begin if (exp_r8.size() != 0) chk("ready8_error", 64'(err8), 64'(exp_r8.pop_front())); else extra("ready8"); end
    end

    task automatic wait_rdy(input bit want_d, input bit junk);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (want_d ? (sel ? d_rdy8 : d_rdy) : (sel ? x_rdy8 : x_rdy)) begin
                ok = 1'b1;
                break;
            end
            xen = junk;
            xin = 64'd55;
            @(negedge CLK);
        end
        xen = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting for ready", want_d ? "d_ready" : "x_ready");
        end
    endtask

    task automatic run(input bit s, input bit md, input int l, input int x, input int t,
                       input bit junk, input bit abort);
        sel = s; mode = md; sl = 64'(l); sx = 64'(x); st = 64'(t);
        if (s) start8 = 1'b1; else start = 1'b1;
        @(negedge CLK);
        start = 1'b0; start8 = 1'b0;
        chk("busy_after_start", 64'(s ? busy8 : busy), 64'd1);
        chk("error_cleared", 64'(s ? err8 : err), 64'd0);
        for (int ti = 0; ti < t; ti++) begin
            for (int xi = 0; xi < x; xi++) begin
                wait_rdy(1'b0, junk);
                xen = 1'b1; xin = xs[ti*x+xi];
                @(negedge CLK);
                xen = 1'b0;
            end
            for (int li = 0; li < l; li++) begin
                wait_rdy(1'b1, junk);
                den = 1'b1; din = ds[ti*l+li];
                xen = junk; xin = 64'd77;
                @(negedge CLK);
                den = 1'b0; xen = 1'b0;
            end
        end
        if (abort) begin
            chk("busy_in_accum", 64'(busy), 64'd1);
            RST = 1'b1;
            #1;
            chk("abort_ctrl", 64'({ready, busy, err, x_rdy, d_rdy, w_en, b_en}), 64'd0);
            chk("abort_w_out", w_out, 64'd0);
            chk("abort_b_out", b_out, 64'd0);
            repeat (2) @(negedge CLK);
            RST = 1'b0;
            return;
        end
        for (int i = 0; i < 200 && (s ? busy8 : busy); i++) begin
            xen = junk; xin = 64'd66;
            @(negedge CLK);
        end
        xen = 1'b0;
        if (s ? busy8 : busy) begin
            checks++;
            failures++;
            $display("FAIL run_done: timeout, busy still high");
        end
        @(negedge CLK);
    endtask

    task automatic bad_start(input int l, input int x, input int t);
        sel = 1'b0; sl = 64'(l); sx = 64'(x); st = 64'(t);
        start = 1'b1;
        exp_r.push_back(1'b1);
        @(negedge CLK);
        start = 1'b0;
        chk("bad_error", 64'(err), 64'd1);
        chk("bad_busy", 64'(busy), 64'd0);
        @(negedge CLK);
        chk("bad_ready_one_cycle", 64'(ready), 64'd0);
        chk("bad_error_held", 64'(err), 64'd1);
    endtask

    task automatic push_basic();
        xs[0] = 64'd1; xs[1] = 64'd2; ds[0] = 64'd3; ds[1] = 64'd4;
        exp_w.push_back(64'd3); exp_w.push_back(64'd6); exp_w.push_back(64'd4); exp_w.push_back(64'd8);
        exp_b.push_back(64'd3); exp_b.push_back(64'd4);
        exp_r.push_back(1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; start = 1'b0; start8 = 1'b0; mode = 1'b0; xen = 1'b0; den = 1'b0;
        sl = '0; sx = '0; st = '0; xin = '0; din = '0; sel = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ctrl", 64'({ready, busy, err, x_rdy, d_rdy, w_en, b_en}), 64'd0);
        chk("rst_w_out", w_out, 64'd0);
        chk("rst_b_out", b_out, 64'd0);
        chk("rst_ctrl8", 64'({ready8, busy8, err8, x_rdy8, d_rdy8, w_en8, b_en8, w_out8, b_out8}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 2x2, T=1, direct delta
        push_basic();
        run(1'b0, 1'b0, 2, 2, 1, 1'b0, 1'b0);
        chk("w_hold", w_out, 64'd8);
        chk("b_hold", b_out, 64'd4);

        // 1x1, T=2, differentiated delta: 5*2 + (7-5)*2 = 14, db = 5 + 2 = 7
        xs[0] = 64'd2; xs[1] = 64'd2; ds[0] = 64'd5; ds[1] = 64'd7;
        exp_w.push_back(64'd14); exp_b.push_back(64'd7); exp_r.push_back(1'b0);
        run(1'b0, 1'b1, 1, 1, 2, 1'b0, 1'b0);

        // Illegal sizes
        bad_start(0, 2, 1);
        bad_start(2, 5, 1);
        bad_start(2, 2, 0);

        // Stray X_IN_ENABLE during LOAD_D / ACCUM / output
        push_basic();
        run(1'b0, 1'b0, 2, 2, 1, 1'b1, 1'b0);

        // Reset during ACCUM, then rerun
        xs[0] = 64'd1; xs[1] = 64'd2; ds[0] = 64'd3; ds[1] = 64'd4;
        run(1'b0, 1'b0, 2, 2, 1, 1'b0, 1'b1);
        @(negedge CLK);
        chk("post_abort_w_out", w_out, 64'd0);
        push_basic();
        run(1'b0, 1'b0, 2, 2, 1, 1'b0, 1'b0);

        // L=3, X=1 with negative x
        xs[0] = -64'sd2; ds[0] = 64'd1; ds[1] = 64'd2; ds[2] = 64'd3;
        exp_w.push_back(-64'sd2); exp_w.push_back(-64'sd4); exp_w.push_back(-64'sd6);
        exp_b.push_back(64'd1); exp_b.push_back(64'd2); exp_b.push_back(64'd3);
        exp_r.push_back(1'b0);
        run(1'b0, 1'b0, 3, 1, 1, 1'b0, 1'b0);

        // L=1, X=MAX_X with negative delta
        xs[0] = 64'd1; xs[1] = 64'd2; xs[2] = 64'd3; xs[3] = 64'd4; ds[0] = -64'sd3;
        exp_w.push_back(-64'sd3); exp_w.push_back(-64'sd6); exp_w.push_back(-64'sd9); exp_w.push_back(-64'sd12);
        exp_b.push_back(-64'sd3);
        exp_r.push_back(1'b0);
        run(1'b0, 1'b0, 1, 4, 1, 1'b0, 1'b0);

        // 8-bit instance: 127*127 = 16129 = 0x3F01
        xs[0] = 64'd127; ds[0] = 64'd127;
`ifdef MODEL_GRADIENT_SATURATE_EN
        exp_w8.push_back(8'd127);
`else
        exp_w8.push_back(8'd1);
`endif
        exp_b8.push_back(8'd127);
        exp_r8.push_back(1'b0);
        run(1'b1, 1'b0, 1, 1, 1, 1'b0, 1'b0);

        repeat (3) @(negedge CLK);
        chk("pending_w",  64'(exp_w.size()),  64'd0);
        chk("pending_b",  64'(exp_b.size()),  64'd0);
        chk("pending_r",  64'(exp_r.size()),  64'd0);
        chk("pending_w8", 64'(exp_w8.size()), 64'd0);
        chk("pending_b8", 64'(exp_b8.size()), 64'd0);
        chk("pending_r8", 64'(exp_r8.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/model_controller_gradient_accumulator.md
MODEL_CONTROLLER_GRADIENT_ACCUMULATOR -- requirements
Module: model_controller_gradient_accumulator

Interface
REQ-001 Parameter DATA_SIZE, default 64, element width, two's complement signed.
REQ-002 Parameter MAX_L, default 4, maximum output length L (rows of dW, length of db).
REQ-003 Parameter MAX_X, default 4, maximum input length X (columns of dW).
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 START  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 READY  output  1  one-cycle pulse when a run completes, normally or by error.
REQ-008 BUSY  output  1  high in every state except IDLE.
REQ-009 ERROR  output  1  level, set by an illegal size at START, cleared by next accepted START.
REQ-010 MODE_IN  input  1  0 = direct delta, 1 = differentiated delta; latched at START.
REQ-011 SIZE_L_IN  input  DATA_SIZE  L; latched at START.
REQ-012 SIZE_X_IN  input  DATA_SIZE  X; latched at START.
REQ-013 SIZE_T_IN  input  DATA_SIZE  number of time steps T; latched at START.
REQ-014 X_IN_ENABLE  input  1  X_IN valid this cycle.
REQ-015 X_IN  input  DATA_SIZE  element x(t;x).
REQ-016 X_IN_READY  output  1  high only in LOAD_X.
REQ-017 D_IN_ENABLE  input  1  D_IN valid this cycle.
REQ-018 D_IN  input  DATA_SIZE  element d(t;l).
REQ-019 D_IN_READY  output  1  high only in LOAD_D.
REQ-020 W_OUT_ENABLE  output  1  W_OUT valid this cycle.
REQ-021 W_OUT  output  DATA_SIZE  dW element, row-major (l outer, x inner).
REQ-022 B_OUT_ENABLE  output  1  B_OUT valid this cycle.
REQ-023 B_OUT  output  DATA_SIZE  db element, l ascending.

Function
REQ-024 Computed: dW(l;x) = sum over t in 0..T-1 of d*(t;l)*x(t;x); db(l) = sum over t of d*(t;l).
REQ-025 d*(t;l) = d(t;l) when MODE=0; d(t;l) - d(t-1;l) when MODE=1, with d(-1;l) = 0.
REQ-026 FSM states: IDLE, LOAD_X, LOAD_D, ACCUM, OUT_W, OUT_B.
REQ-027 IDLE -> LOAD_X on START with 1<=L<=MAX_L, 1<=X<=MAX_X, T>=1; accumulators and previous-delta store cleared on the same edge.
REQ-028 Illegal sizes at START: stay IDLE, ERROR=1, READY pulses the following cycle.
REQ-029 LOAD_X: one element stored per cycle with X_IN_ENABLE=1; after X elements -> LOAD_D.
REQ-030 LOAD_D: one element stored per cycle with D_IN_ENABLE=1; after L elements -> ACCUM.
REQ-031 Enables in any other state are ignored; data never stored.
REQ-032 ACCUM: one (l,x) MAC per cycle, L*X cycles; db(l) updated on the x=0 cycle; d(t) copied into previous-delta store at exit.
REQ-033 ACCUM exit: t+1<T -> LOAD_X; else -> OUT_W.
REQ-034 Product = low DATA_SIZE bits of the signed full product; sums wrap modulo 2^DATA_SIZE (see REQ-041).
REQ-035 OUT_W: L*X consecutive cycles, W_OUT_ENABLE=1; then OUT_B: L cycles, B_OUT_ENABLE=1.
REQ-036 READY pulses the cycle after the last B_OUT; FSM returns to IDLE on the same edge.
REQ-037 START outside IDLE is ignored.
REQ-038 W_OUT/B_OUT hold their last value while their enables are low.

Reset
REQ-039 RST high: FSM=IDLE; all accumulators, stores and counters cleared; every output 0, including ERROR.
REQ-040 RST mid-run aborts the run with no READY pulse; a new START is required afterwards.

Configuration
REQ-041 Macro MODEL_GRADIENT_SATURATE_EN:
- Defined: each product and each accumulator update saturates to the signed DATA_SIZE limits.
- Undefined: wrap-around per REQ-034.

Verification
REQ-042 L=2, X=2, T=1, MODE=0, x=(1,2), d=(3,4) -> W_OUT 3,6,4,8 -> B_OUT 3,4 -> READY pulse.
REQ-043 L=1, X=1, T=2, MODE=1, x=(2),(2), d=(5),(7) -> W_OUT 14, B_OUT 7.
REQ-044 START with SIZE_L_IN=0 -> ERROR=1, READY pulse next cycle, BUSY stays 0.
REQ-045 X_IN_ENABLE pulsed during LOAD_D and ACCUM -> results identical to REQ-042.
REQ-046 RST asserted during ACCUM -> all outputs 0, no READY; rerun of REQ-042 gives the same values.
REQ-047 DATA_SIZE=8, x=127, d=127: macro defined -> W_OUT=127; undefined -> W_OUT=1 (low byte of 16129).
